// File: rtl/dac_spi_sine_gen_if.sv
// Pin-level bundle between the sine generator and the SPI DAC / status LED.
// master: the generator (drives the DAC pins, reads the static controls)
// slave : board side / bench (drives gain and shutdown, observes the DAC pins)
interface dac_spi_sine_gen_if;
  logic gain;
  logic shutdown;
  logic dac_csn;
  logic dac_sclk;
  logic dac_sdi;
  logic led;

  modport master (
    input  gain,
    input  shutdown,
    output dac_csn,
    output dac_sclk,
    output dac_sdi,
    output led
  );

  modport slave (
    output gain,
    output shutdown,
    input  dac_csn,
    input  dac_sclk,
    input  dac_sdi,
    input  led
  );
endinterface

// File: rtl/dac_spi_sine_gen.sv
// Sine generator for a 12-bit MCP4821-style SPI DAC.
// One 16-bit frame every 500 clocks, SCLK = clk/10, MSB first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | CSn high, waiting for the sample tick to load a frame
// ST_SHIFT| CSn low, 16 bits shifted out, 10 clocks per bit
// ST_DONE | SCLK low, CSn held low 5 more clocks before release
module dac_spi_sine_gen (
  input  logic                clk,
  input  logic                rst_n,
  dac_spi_sine_gen_if.master  dac
);

  localparam logic [8:0] TICK_LAST  = 9'd499;
  localparam logic [3:0] PHASE_LAST = 4'd9;
  localparam logic [2:0] HOLD_LAST  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  timer_q;
  logic        tick;
  logic [5:0]  k_q, k_d;
  logic [15:0] word_q, word_d;
  logic [3:0]  bit_q, bit_d;
  logic [3:0]  phase_q, phase_d;
  logic [2:0]  hold_q, hold_d;
  logic        csn_q, csn_d;
  logic        sclk_q, sclk_d;
  logic        sdi_q, sdi_d;
  logic        led_q, led_d;
  logic [11:0] lut_val;
  logic [15:0] frame_word;

  assign tick = (timer_q == TICK_LAST);

  // Free-running sample timer, 0..499.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (tick) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 9'd1;
    end
  end

  // Full-period sine table: round(2048 + 2047*sin(2*pi*k/64)).
  always_comb begin
    lut_val = 12'd2048;
    case (k_q)
      6'd0:  lut_val = 12'd2048;  6'd1:  lut_val = 12'd2249;
      6'd2:  lut_val = 12'd2447;  6'd3:  lut_val = 12'd2642;
      6'd4:  lut_val = 12'd2831;  6'd5:  lut_val = 12'd3013;
      6'd6:  lut_val = 12'd3185;  6'd7:  lut_val = 12'd3347;
      6'd8:  lut_val = 12'd3495;  6'd9:  lut_val = 12'd3630;
      6'd10: lut_val = 12'd3750;  6'd11: lut_val = 12'd3853;
      6'd12: lut_val = 12'd3939;  6'd13: lut_val = 12'd4007;
      6'd14: lut_val = 12'd4056;  6'd15: lut_val = 12'd4085;
      6'd16: lut_val = 12'd4095;  6'd17: lut_val = 12'd4085;
      6'd18: lut_val = 12'd4056;  6'd19: lut_val = 12'd4007;
      6'd20: lut_val = 12'd3939;  6'd21: lut_val = 12'd3853;
      6'd22: lut_val = 12'd3750;  6'd23: lut_val = 12'd3630;
      6'd24: lut_val = 12'd3495;  6'd25: lut_val = 12'd3347;
      6'd26: lut_val = 12'd3185;  6'd27: lut_val = 12'd3013;
      6'd28: lut_val = 12'd2831;  6'd29: lut_val = 12'd2642;
      6'd30: lut_val = 12'd2447;  6'd31: lut_val = 12'd2249;
      6'd32: lut_val = 12'd2048;  6'd33: lut_val = 12'd1847;
      6'd34: lut_val = 12'd1649;  6'd35: lut_val = 12'd1454;
      6'd36: lut_val = 12'd1265;  6'd37: lut_val = 12'd1083;
      6'd38: lut_val = 12'd911;   6'd39: lut_val = 12'd749;
      6'd40: lut_val = 12'd601;   6'd41: lut_val = 12'd466;
      6'd42: lut_val = 12'd346;   6'd43: lut_val = 12'd243;
      6'd44: lut_val = 12'd157;   6'd45: lut_val = 12'd89;
      6'd46: lut_val = 12'd40;    6'd47: lut_val = 12'd11;
      6'd48: lut_val = 12'd1;     6'd49: lut_val = 12'd11;
      6'd50: lut_val = 12'd40;    6'd51: lut_val = 12'd89;
      6'd52: lut_val = 12'd157;   6'd53: lut_val = 12'd243;
      6'd54: lut_val = 12'd346;   6'd55: lut_val = 12'd466;
      6'd56: lut_val = 12'd601;   6'd57: lut_val = 12'd749;
      6'd58: lut_val = 12'd911;   6'd59: lut_val = 12'd1083;
      6'd60: lut_val = 12'd1265;  6'd61: lut_val = 12'd1454;
      6'd62: lut_val = 12'd1649;  6'd63: lut_val = 12'd1847;
      default: lut_val = 12'd2048;
    endcase
  end

  // Channel A, gain bit, active-low shutdown bit, 12-bit code.
  assign frame_word = {2'b00, dac.gain, ~dac.shutdown, lut_val};

  // Next-state and next-output logic; all pins are registered below.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    word_d  = word_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    csn_d   = csn_q;
    sclk_d  = sclk_q;
    sdi_d   = sdi_q;
    case (state_q)
      ST_IDLE: begin
        csn_d  = 1'b1;
        sclk_d = 1'b0;
        sdi_d  = 1'b0;
        if (tick) begin
          word_d  = frame_word;
          k_d     = k_q + 6'd1;
          csn_d   = 1'b0;
          sdi_d   = frame_word[15];
          bit_d   = 4'd15;
          phase_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          if (bit_q == 4'd0) begin
            hold_d  = '0;
            state_d = ST_DONE;
          end else begin
            bit_d = bit_q - 4'd1;
            sdi_d = word_q[bit_q - 4'd1];
          end
        end else begin
          phase_d = phase_q + 4'd1;
          // SCLK is high while the phase that is about to start is 5..9.
          sclk_d  = (phase_q >= 4'd4);
        end
      end
      ST_DONE: begin
        sclk_d = 1'b0;
        if (hold_q == HOLD_LAST) begin
          csn_d   = 1'b1;
          sdi_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 3'd1;
        end
      end
      default: begin
        csn_d   = 1'b1;
        sclk_d  = 1'b0;
        sdi_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    led_d = ~csn_d;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      phase_q <= '0;
      hold_q  <= '0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      csn_q   <= csn_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
      led_q   <= led_d;
    end
  end

  assign dac.dac_csn  = csn_q;
  assign dac.dac_sclk = sclk_q;
  assign dac.dac_sdi  = sdi_q;
  assign dac.led      = led_q;

endmodule

// File: tb/tb_dac_spi_sine_gen.sv
// Bench for dac_spi_sine_gen: decodes SPI frames from the pins and checks
// words, frame timing, LED tracking and reset behaviour.
module tb_dac_spi_sine_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dac_spi_sine_gen_if dac ();

  dac_spi_sine_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dac   (dac)
  );

  // Rising-edge cycle counter used to time frame starts.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] lut_model(input int k);
    real v;
    v = 2048.0 + 2047.0 * $sin(2.0 * 3.141592653589793 * k / 64.0);
    return 12'($rtoi(v + 0.5));
  endfunction

  // Waits (bounded) for CSn to fall, then decodes one frame at negedges.
  // toggle_at / abort_at: frame offset at which to flip gain / assert reset.
  task automatic capture(input int toggle_at, input int abort_at,
                         output logic [15:0] w, output int fall_cyc,
                         output int rises, output int low_len,
                         output int led_err, output int sdi_err);
    int budget;
    int off;
    logic prev_sclk;
    logic prev_sdi;
    w = '0; rises = 0; low_len = 0; led_err = 0; sdi_err = 0; fall_cyc = -1;
    budget = 0;
    while (dac.dac_csn !== 1'b0 && budget < 1200) begin
      @(negedge clk);
      budget++;
    end
    if (dac.dac_csn !== 1'b0) begin
      chk("csn_fall_timeout", 32'd1, 32'd0);
      return;
    end
    fall_cyc  = cyc;
    prev_sclk = dac.dac_sclk;
    prev_sdi  = dac.dac_sdi;
    off = 0;
    while (dac.dac_csn === 1'b0 && off < 400) begin
      if (dac.led !== ~dac.dac_csn) led_err++;
      if (dac.dac_sclk === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        w = {w[14:0], dac.dac_sdi};
      end
      if (dac.dac_sdi !== prev_sdi && (off % 10) != 0) sdi_err++;
      prev_sclk = dac.dac_sclk;
      prev_sdi  = dac.dac_sdi;
      if (off == toggle_at) dac.gain = ~dac.gain;
      if (off == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_csn",  32'(dac.dac_csn),  32'd1);
        chk("abort_sclk", 32'(dac.dac_sclk), 32'd0);
        chk("abort_sdi",  32'(dac.dac_sdi),  32'd0);
        chk("abort_led",  32'(dac.led),      32'd0);
        low_len = off;
        return;
      end
      @(negedge clk);
      off++;
    end
    low_len = off;
    if (dac.led !== ~dac.dac_csn) led_err++;
  endtask

  initial begin
    logic [15:0] w;
    int fc, rs, ll, le, se, prev_fc, rel;
    dac.gain     = 1'b1;
    dac.shutdown = 1'b0;
    rst_n        = 1'b0;
    prev_fc      = 0;
    repeat (3) @(negedge clk);
    chk("rst_csn",  32'(dac.dac_csn),  32'd1);
    chk("rst_sclk", 32'(dac.dac_sclk), 32'd0);
    chk("rst_sdi",  32'(dac.dac_sdi),  32'd0);
    chk("rst_led",  32'(dac.led),      32'd0);
    rst_n = 1'b1;
    rel = cyc;

    // 65 frames: full table sweep plus wrap back to k=0.
    for (int i = 0; i < 65; i++) begin
      capture(-1, -1, w, fc, rs, ll, le, se);
      chk($sformatf("word_%0d", i), 32'(w), 32'({4'b0011, lut_model(i % 64)}));
      if (i == 0) chk("first_fall", 32'(fc - rel), 32'd500);
      else        chk($sformatf("spacing_%0d", i), 32'(fc - prev_fc), 32'd500);
      chk($sformatf("rises_%0d", i), 32'(rs), 32'd16);
      chk($sformatf("csn_low_%0d", i), 32'(ll), 32'd165);
      chk($sformatf("led_%0d", i), 32'(le), 32'd0);
      chk($sformatf("sdi_edge_%0d", i), 32'(se), 32'd0);
      case (i)
        0:  chk("hand_k0",  32'(w), 32'h3800);
        1:  chk("hand_k1",  32'(w), 32'h38C9);
        2:  chk("hand_k2",  32'(w), 32'h398F);
        16: chk("hand_k16", 32'(w), 32'h3FFF);
        48: chk("hand_k48", 32'(w), 32'h3001);
        64: chk("hand_wrap", 32'(w), 32'h3800);
        default: ;
      endcase
      prev_fc = fc;
    end

    // gain=2x, shutdown asserted, fresh from reset.
    rst_n = 1'b0;
    dac.gain     = 1'b0;
    dac.shutdown = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    capture(-1, -1, w, fc, rs, ll, le, se);
    chk("gain0_shdn_word", 32'(w), 32'h0800);
    chk("gain0_shdn_fall", 32'(fc - rel), 32'd500);

    // Gain flipped mid-frame only affects the following frame.
    rst_n = 1'b0;
    dac.gain     = 1'b1;
    dac.shutdown = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(50, -1, w, fc, rs, ll, le, se);
    chk("toggle_cur_word", 32'(w), 32'h3800);
    capture(-1, -1, w, fc, rs, ll, le, se);
    chk("toggle_next_word", 32'(w), 32'h18C9);
    dac.gain = 1'b1;

    // Reset 80 cycles into a frame, then restart from k=0.
    capture(-1, 80, w, fc, rs, ll, le, se);
    chk("abort_offset", 32'(ll), 32'd80);
    repeat (3) @(negedge clk);
    chk("abort_hold_csn", 32'(dac.dac_csn), 32'd1);
    rst_n = 1'b1;
    rel = cyc;
    capture(-1, -1, w, fc, rs, ll, le, se);
    chk("restart_fall", 32'(fc - rel), 32'd500);
    chk("restart_word", 32'(w), 32'h3800);
    chk("restart_rises", 32'(rs), 32'd16);
    chk("restart_low", 32'(ll), 32'd165);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
